// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter sharing the 16-bit peripheral register bus
// Optional grant locking with idle watchdog is enabled by defining ARB_LOCK_EN.
module reg_bus_arbiter #(
  parameter int          NREQ      = 2,
  parameter int          RD_LAT    = 2,
  parameter logic [15:0] IDLE_ADDR = 16'hFFFF,
  parameter int          LOCK_MAX  = 64
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*16-1:0]   req_addr,
  input  logic [NREQ*2-1:0]    req_be,
  input  logic [NREQ*16-1:0]   req_wdata,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [15:0]          rdata,
  output logic [15:0]          rdaddr,
  output logic [15:0]          wraddr,
  output logic [1:0]           be,
  output logic                 write,
  output logic [15:0]          wrdata,
  input  logic [15:0]          rddata,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   sel;
  logic            found;
  logic [NREQ-1:0] elig;
  logic            lock_held;

  logic [RD_LAT:0] tag_vld;
  logic [IW-1:0]   tag_own [RD_LAT:0];

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && elig[(int'(last_gnt) + k) % NREQ]) begin
        found = 1'b1;
        sel   = IW'((int'(last_gnt) + k) % NREQ);
      end
    end
  end

  assign gnt = (found && !sclr) ? (ONE << sel) : '0;

  logic        g_we;
  logic [15:0] g_addr;
  logic [1:0]  g_be;
  logic [15:0] g_wdata;
  logic        g_rd;

  assign g_we    = req_we[sel];
  assign g_addr  = req_addr[16*sel +: 16];
  assign g_be    = req_be[2*sel +: 2];
  assign g_wdata = req_wdata[16*sel +: 16];
  assign g_rd    = (|gnt) && !g_we;

  always_ff @(posedge clk) begin
    if (sclr) begin
      last_gnt <= IW'(NREQ - 1);
      rdaddr   <= IDLE_ADDR;
      wraddr   <= IDLE_ADDR;
      be       <= '0;
      write    <= 1'b0;
      wrdata   <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      tag_vld  <= '0;
      for (int s = 0; s <= RD_LAT; s++) tag_own[s] <= '0;
    end else begin
      rdaddr <= IDLE_ADDR;
      wraddr <= IDLE_ADDR;
      be     <= '0;
      write  <= 1'b0;
      if (|gnt) begin
        last_gnt <= sel;
        if (g_we) begin
          write  <= 1'b1;
          wraddr <= g_addr;
          be     <= g_be;
          wrdata <= g_wdata;
        end else begin
          rdaddr <= g_addr;
        end
      end
      // Stage 0 is the bus address cycle; data is captured after the last stage.
      tag_vld <= {tag_vld[RD_LAT-1:0], g_rd};
      for (int s = RD_LAT; s > 0; s--) tag_own[s] <= tag_own[s-1];
      tag_own[0] <= sel;
      if (tag_vld[RD_LAT]) begin
        rvalid <= ONE << tag_own[RD_LAT];
        rdata  <= rddata;
      end else begin
        rvalid <= '0;
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [IW-1:0] lock_owner;
  logic [CW-1:0] wd_cnt;

  assign elig = lock_held ? (req & (ONE << lock_owner)) : req;

  // Watchdog frees a lock whose owner walked away without a closing access.
  always_ff @(posedge clk) begin
    if (sclr) begin
      lock_held  <= 1'b0;
      lock_owner <= '0;
      wd_cnt     <= '0;
    end else if (|gnt) begin
      lock_held  <= req_lock[sel];
      lock_owner <= sel;
      wd_cnt     <= '0;
    end else if (lock_held && !req[lock_owner]) begin
      if (wd_cnt == CW'(LOCK_MAX - 1)) begin
        lock_held <= 1'b0;
        wd_cnt    <= '0;
      end else begin
        wd_cnt <= wd_cnt + CW'(1);
      end
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_held   = 1'b0;
  assign elig        = req;
`endif

  assign busy = (|tag_vld) | lock_held;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - scoreboard bench for reg_bus_arbiter (directed vectors)
module tb_reg_bus_arbiter;
  localparam int NREQ = 2;
  localparam int RD_LAT = 2;
  localparam logic [15:0] IDLE = 16'hFFFF;

  logic                clk = 1'b0;
  logic                sclr = 1'b1;
  logic [NREQ-1:0]     req = '0, req_we = '0, req_lock = '0;
  logic [NREQ*16-1:0]  req_addr = '0, req_wdata = '0;
  logic [NREQ*2-1:0]   req_be = '0;
  logic [NREQ-1:0]     gnt, rvalid;
  logic [15:0]         rdata, rdaddr, wraddr, wrdata;
  logic [1:0]          be;
  logic                write, busy;
  logic [15:0]         rddata = '0, d1 = '0;

  reg_bus_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .IDLE_ADDR(IDLE), .LOCK_MAX(64)) dut (
    .clk(clk), .sclr(sclr), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .req_lock(req_lock), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .rdaddr(rdaddr), .wraddr(wraddr), .be(be),
    .write(write), .wrdata(wrdata), .rddata(rddata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(input logic [15:0] a);
    if (a == IDLE) return 16'h0000;
    if (a == 16'h0102) return 16'hBEEF;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Bank register followed by the OR register.
  always @(posedge clk) begin
    d1     <= model(rdaddr);
    rddata <= d1;
  end

  typedef struct { int cyc; int owner; logic [15:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [15:0] addr; logic [1:0] be; logic [15:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t re;
  wr_exp_t we;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!sclr) begin
      if (rvalid !== '0) begin
        if (rd_q.size() == 0) check("unexpected_rvalid", 32'(rvalid), 32'h0);
        else begin
          re = rd_q.pop_front();
          check("rvalid_owner", 32'(rvalid), 32'(1 << re.owner));
          check("rdata", 32'(rdata), 32'(re.data));
          check("rd_cycle", cyc, re.cyc);
        end
      end
      if (write !== 1'b0) begin
        if (wr_q.size() == 0) check("unexpected_write", 32'(write), 32'h0);
        else begin
          we = wr_q.pop_front();
          check("wraddr", 32'(wraddr), 32'(we.addr));
          check("wr_be", 32'(be), 32'(we.be));
          check("wrdata", 32'(wrdata), 32'(we.data));
          check("rdaddr_idle_on_write", 32'(rdaddr), 32'(IDLE));
          check("wr_cycle", cyc, we.cyc);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the grant cycle with req dropped.
  task automatic access(input int i, input bit w, input logic [15:0] a, input logic [1:0] b,
                        input logic [15:0] d, input bit lk, input bit expect_resp);
    bit ok = 0;
    req[i] = 1'b1; req_we[i] = w; req_lock[i] = lk;
    req_addr[16*i +: 16] = a; req_be[2*i +: 2] = b; req_wdata[16*i +: 16] = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (gnt[i]) begin ok = 1; break; end
    end
    check("gnt_seen", 32'(ok), 32'h1);
    if (ok) begin
      check("gnt_onehot", 32'(gnt), 32'(1 << i));
      if (expect_resp) begin
        if (w) wr_q.push_back('{cyc + 1, a, b, d});
        else   rd_q.push_back('{cyc + RD_LAT + 2, i, model(a)});
      end
    end
    @(posedge clk); #1;
    req[i] = 1'b0; req_lock[i] = 1'b0;
  endtask

  task automatic pulse_reset();
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 sclr = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_write", 32'(write), 32'h0);
    check("rst_be", 32'(be), 32'h0);
    check("rst_wrdata", 32'(wrdata), 32'h0);
    check("rst_rdaddr", 32'(rdaddr), 32'(IDLE));
    check("rst_wraddr", 32'(wraddr), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // 1: single read
    access(0, 1'b0, 16'h0102, 2'b11, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_rdaddr", 32'(rdaddr), 32'h0102);
    check("t1_wraddr_idle", 32'(wraddr), 32'(IDLE));
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;

    // 2: two requesters held, alternating grants
    pulse_reset();
    req_we = '0;
    req_addr[0 +: 16] = 16'h0200;
    req_addr[16 +: 16] = 16'h0300;
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      automatic int own = n % 2;
      @(negedge clk);
      check("t2_gnt", 32'(gnt), 32'(1 << own));
      rd_q.push_back('{cyc + RD_LAT + 2, own, model(req_addr[16*own +: 16])});
      @(posedge clk); #1;
      req_addr[16*own +: 16] = req_addr[16*own +: 16] + 16'h0001;
    end
    req = '0;
    repeat (8) @(posedge clk);
    #1;

    // 3: write from requester 1
    access(1, 1'b1, 16'h0180, 2'b01, 16'h00A5, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // 4: reset with two reads in flight
    access(0, 1'b0, 16'h0400, 2'b11, 16'h0000, 1'b0, 1'b0);
    access(0, 1'b0, 16'h0401, 2'b11, 16'h0000, 1'b0, 1'b0);
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    @(negedge clk);
    check("t4_rvalid", 32'(rvalid), 32'h0);
    check("t4_rdata", 32'(rdata), 32'h0);
    check("t4_write", 32'(write), 32'h0);
    check("t4_rdaddr", 32'(rdaddr), 32'(IDLE));
    check("t4_wraddr", 32'(wraddr), 32'(IDLE));
    check("t4_busy", 32'(busy), 32'h0);
    repeat (6) @(posedge clk);
    #1;

`ifdef ARB_LOCK_EN
    // 5: locked pair from requester 0 while requester 1 waits
    req[1] = 1'b1; req_we[1] = 1'b0; req_addr[16 +: 16] = 16'h0200;
    req[0] = 1'b1; req_we[0] = 1'b0; req_lock[0] = 1'b1; req_addr[0 +: 16] = 16'h0100;
    @(negedge clk);
    check("t5_gnt_a", 32'(gnt), 32'h1);
    rd_q.push_back('{cyc + RD_LAT + 2, 0, model(16'h0100)});
    @(posedge clk); #1;
    req_lock[0] = 1'b0; req_addr[0 +: 16] = 16'h0101;
    @(negedge clk);
    check("t5_gnt_b", 32'(gnt), 32'h1);
    check("t5_busy", 32'(busy), 32'h1);
    rd_q.push_back('{cyc + RD_LAT + 2, 0, model(16'h0101)});
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("t5_gnt_c", 32'(gnt), 32'h2);
    rd_q.push_back('{cyc + RD_LAT + 2, 1, model(16'h0200)});
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 6: abandoned lock is freed by the watchdog
    access(0, 1'b0, 16'h0110, 2'b11, 16'h0000, 1'b1, 1'b1);
    begin
      int waited = 0;
      bit ok = 0;
      req[1] = 1'b1; req_we[1] = 1'b0; req_addr[16 +: 16] = 16'h0210;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (gnt[1]) begin ok = 1; break; end
        waited++;
      end
      check("t6_gnt_seen", 32'(ok), 32'h1);
      check("t6_wait_cycles", waited, 64);
      if (ok) rd_q.push_back('{cyc + RD_LAT + 2, 1, model(16'h0210)});
      @(posedge clk); #1;
      req[1] = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
`endif

    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rd_queue_drained", rd_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
